// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand forwarding, load-use hazard detection and the
// registered ALU operand/control bundle, with a saturating load-use stall counter.
module alu_issue_stage #(
  parameter int XLEN     = 32,
  parameter int OP_SEL_W = 4,
  parameter int BR_SEL_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  logic [XLEN-1:0]     id_pc_i,
  input  logic [4:0]          id_rs1_i,
  input  logic [4:0]          id_rs2_i,
  input  logic [4:0]          id_rd_i,
  input  logic [XLEN-1:0]     id_rs1_data_i,
  input  logic [XLEN-1:0]     id_rs2_data_i,
  input  logic [XLEN-1:0]     id_imm_i,
  input  logic [1:0]          id_a_sel_i,
  input  logic                id_b_imm_i,
  input  logic [OP_SEL_W-1:0] id_op_sel_i,
  input  logic [BR_SEL_W-1:0] id_branch_sel_i,
  input  logic                id_reg_write_i,
  input  logic                id_is_load_i,
  input  logic [XLEN-1:0]     ex_result_i,
  input  logic                mem_valid_i,
  input  logic                mem_reg_write_i,
  input  logic [4:0]          mem_rd_i,
  input  logic [XLEN-1:0]     mem_result_i,
  input  logic                wb_valid_i,
  input  logic                wb_reg_write_i,
  input  logic [4:0]          wb_rd_i,
  input  logic [XLEN-1:0]     wb_data_i,
  input  logic                ex_hold_i,
  input  logic                flush_i,
  output logic                ex_valid_o,
  output logic [XLEN-1:0]     ex_pc_o,
  output logic [XLEN-1:0]     ex_a_o,
  output logic [XLEN-1:0]     ex_b_o,
  output logic [XLEN-1:0]     ex_store_data_o,
  output logic [OP_SEL_W-1:0] ex_op_sel_o,
  output logic [BR_SEL_W-1:0] ex_branch_sel_o,
  output logic [4:0]          ex_rd_o,
  output logic                ex_reg_write_o,
  output logic                ex_is_load_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [XLEN-1:0]     store_data;
    logic [OP_SEL_W-1:0] op_sel;
    logic [BR_SEL_W-1:0] br_sel;
    logic [4:0]          rd;
    logic                reg_write;
    logic                is_load;
  } ex_t;

  ex_t             ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            hazard;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, a_val;

  // A load in EX has no result yet, so it is excluded from EX forwarding.
  function automatic logic [XLEN-1:0] forward(input logic [4:0] r,
                                              input logic [XLEN-1:0] rf_data);
    if (r == 5'd0)
      return '0;
    else if (ex_q.valid && ex_q.reg_write && !ex_q.is_load && ex_q.rd == r)
      return ex_result_i;
    else if (mem_valid_i && mem_reg_write_i && mem_rd_i == r)
      return mem_result_i;
    else if (wb_valid_i && wb_reg_write_i && wb_rd_i == r)
      return wb_data_i;
    else
      return rf_data;
  endfunction

  assign hazard = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) && id_valid_i &&
                  ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));

  assign id_ready_o = rst_n_i && (flush_i || (!ex_hold_i && !hazard));

  always_comb begin
    rs1_fwd = forward(id_rs1_i, id_rs1_data_i);
    rs2_fwd = forward(id_rs2_i, id_rs2_data_i);
    case (id_a_sel_i)
      2'd0:    a_val = rs1_fwd;
      2'd1:    a_val = id_pc_i;
      default: a_val = '0;
    endcase
  end

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (!ex_hold_i) begin
      if (hazard) begin
        ex_d = '0;
        if (cnt_q != '1)
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (id_valid_i) begin
        ex_d.valid      = 1'b1;
        ex_d.pc         = id_pc_i;
        ex_d.a          = a_val;
        ex_d.b          = id_b_imm_i ? id_imm_i : rs2_fwd;
        ex_d.store_data = rs2_fwd;
        ex_d.op_sel     = id_op_sel_i;
        ex_d.br_sel     = id_branch_sel_i;
        ex_d.rd         = id_rd_i;
        ex_d.reg_write  = id_reg_write_i;
        ex_d.is_load    = id_is_load_i;
      end else begin
        ex_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid_o      = ex_q.valid;
  assign ex_pc_o         = ex_q.pc;
  assign ex_a_o          = ex_q.a;
  assign ex_b_o          = ex_q.b;
  assign ex_store_data_o = ex_q.store_data;
  assign ex_op_sel_o     = ex_q.op_sel;
  assign ex_branch_sel_o = ex_q.br_sel;
  assign ex_rd_o         = ex_q.rd;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_is_load_o    = ex_q.is_load;
  assign stall_cnt_o     = cnt_q;

endmodule
